// File: rtl/riscv_v_permutation_unit_if.sv
// Request/response bundle between the vector issue queue, the permutation
// unit and writeback.
//
// Handshake: a request transfers on a rising edge where in_valid && in_ready;
// a result transfers on a rising edge where out_valid && out_ready. A source
// holding valid keeps its payload stable until the transfer edge, and the
// unit holds every out_* signal stable while out_valid is high.
interface riscv_v_permutation_unit_if #(
    parameter int DATA_WIDTH = 128,
    parameter int INT_WIDTH  = 32
);
    localparam int NUM_BYTES = DATA_WIDTH / 8;

    logic                  in_valid;
    logic                  in_ready;
    logic [1:0]            op;
    logic [4:0]            osize;
    logic [DATA_WIDTH-1:0] src_data;
    logic [NUM_BYTES-1:0]  src_mask;
    logic [DATA_WIDTH-1:0] old_data;
    logic [NUM_BYTES-1:0]  old_mask;
    logic [INT_WIDTH-1:0]  int_src;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_vdata;
    logic [NUM_BYTES-1:0]  out_vmask;
    logic [INT_WIDTH-1:0]  out_idata;
    logic                  out_err;

    // Issue/writeback side
    modport master (
        output in_valid, op, osize, src_data, src_mask, old_data, old_mask, int_src, out_ready,
        input  in_ready, out_valid, out_vdata, out_vmask, out_idata, out_err
    );

    // Permutation unit side
    modport slave (
        input  in_valid, op, osize, src_data, src_mask, old_data, old_mask, int_src, out_ready,
        output in_ready, out_valid, out_vdata, out_vmask, out_idata, out_err
    );
endinterface

// File: rtl/riscv_v_permutation_unit.sv
// Multi-cycle vector permutation unit: vmv.x.s, vmv.s.x, vslideup, vslidedown.
// Slides move the whole register one element per cycle; the element-0
// moves and zero-offset slides finish in the accept cycle.
module riscv_v_permutation_unit #(
    parameter int DATA_WIDTH = 128,
    parameter int INT_WIDTH  = 32
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        flush,
    riscv_v_permutation_unit_if.slave   bus,
    output logic [1:0]                  dbg_state_o
);
    localparam int NUM_BYTES = DATA_WIDTH / 8;
    localparam int CNT_W     = $clog2(NUM_BYTES) + 1;

    localparam logic [1:0] OP_V2I     = 2'd0;
    localparam logic [1:0] OP_I2V     = 2'd1;
    localparam logic [1:0] OP_SLIDEUP = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                state_q;
    logic [CNT_W-1:0]      cnt_q;
    logic                  slide_up_q;
    logic [2:0]            eidx_q;
    logic [DATA_WIDTH-1:0] acc_data_q;
    logic [NUM_BYTES-1:0]  acc_mask_q;
    logic [NUM_BYTES-1:0]  sel_q;
    logic [DATA_WIDTH-1:0] old_data_q;
    logic [NUM_BYTES-1:0]  old_mask_q;
    logic [DATA_WIDTH-1:0] out_vdata_q;
    logic [NUM_BYTES-1:0]  out_vmask_q;
    logic [INT_WIDTH-1:0]  out_idata_q;
    logic                  out_err_q;

    logic                  legal_d;
    logic [2:0]            eidx_d;
    logic [CNT_W-1:0]      n_d;
    logic [CNT_W-1:0]      k_sat_d;
    logic [CNT_W-1:0]      cnt_d;
    int                    ebits_d;
    int                    ebytes_d;
    logic                  v2i_sign_d;
    logic [DATA_WIDTH-1:0] int_ext_d;
    logic [DATA_WIDTH-1:0] imm_vdata_d;
    logic [NUM_BYTES-1:0]  imm_vmask_d;
    logic [INT_WIDTH-1:0]  imm_idata_d;
    logic [DATA_WIDTH-1:0] acc_data_d;
    logic [NUM_BYTES-1:0]  acc_mask_d;
    logic [NUM_BYTES-1:0]  sel_d;
    logic [DATA_WIDTH-1:0] fin_data_d;
    logic [NUM_BYTES-1:0]  fin_mask_d;

    // Decode the incoming request: element size, legality and slide count min(k, N)
    always_comb begin
        legal_d = (bus.osize != 5'd0) && ((bus.osize & (bus.osize - 5'd1)) == 5'd0);
        eidx_d  = 3'd0;
        for (int i = 0; i < 5; i++) begin
            if (bus.osize[i]) eidx_d = 3'(i);
        end
        ebits_d  = 8 << eidx_d;
        ebytes_d = 1 << eidx_d;
        n_d      = CNT_W'(NUM_BYTES >> eidx_d);
        if (bus.int_src >= INT_WIDTH'(n_d)) k_sat_d = n_d;
        else                                k_sat_d = bus.int_src[CNT_W-1:0];
        cnt_d = (legal_d && bus.op[1]) ? k_sat_d : '0;
    end

    // Results that complete in the accept cycle (element-0 moves, k=0 slides, illegal size)
    always_comb begin
        imm_vdata_d = '0;
        imm_vmask_d = '0;
        imm_idata_d = '0;
        int_ext_d   = {{(DATA_WIDTH - INT_WIDTH){bus.int_src[INT_WIDTH-1]}}, bus.int_src};
        case (eidx_d)
            3'd0:    v2i_sign_d = bus.src_data[7];
            3'd1:    v2i_sign_d = bus.src_data[15];
            3'd2:    v2i_sign_d = bus.src_data[31];
            3'd3:    v2i_sign_d = bus.src_data[63];
            default: v2i_sign_d = bus.src_data[127];
        endcase
        if (legal_d) begin
            case (bus.op)
                OP_V2I: begin
                    imm_vdata_d = bus.old_data;
                    imm_vmask_d = bus.old_mask;
                    for (int b = 0; b < INT_WIDTH; b++) begin
                        imm_idata_d[b] = (b < ebits_d) ? bus.src_data[b] : v2i_sign_d;
                    end
                end
                OP_I2V: begin
                    for (int b = 0; b < DATA_WIDTH; b++) begin
                        imm_vdata_d[b] = (b < ebits_d) ? int_ext_d[b] : bus.old_data[b];
                    end
                    for (int j = 0; j < NUM_BYTES; j++) begin
                        imm_vmask_d[j] = (j < ebytes_d) ? 1'b1 : bus.old_mask[j];
                    end
                end
                default: begin
                    imm_vdata_d = bus.src_data;
                    imm_vmask_d = bus.src_mask;
                end
            endcase
        end
    end

    // One-element shift step; sel tracks which bytes still hold shifted source data
    always_comb begin
        if (slide_up_q) begin
            acc_data_d = acc_data_q << (8 << eidx_q);
            acc_mask_d = acc_mask_q << (1 << eidx_q);
            sel_d      = sel_q << (1 << eidx_q);
        end else begin
            acc_data_d = acc_data_q >> (8 << eidx_q);
            acc_mask_d = acc_mask_q >> (1 << eidx_q);
            sel_d      = sel_q;
        end
        for (int j = 0; j < NUM_BYTES; j++) begin
            fin_data_d[8*j +: 8] = sel_d[j] ? acc_data_d[8*j +: 8] : old_data_q[8*j +: 8];
            fin_mask_d[j]        = sel_d[j] ? acc_mask_d[j] : old_mask_q[j];
        end
    end

    // Control FSM with registered result outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            slide_up_q  <= 1'b0;
            eidx_q      <= 3'd0;
            acc_data_q  <= '0;
            acc_mask_q  <= '0;
            sel_q       <= '0;
            old_data_q  <= '0;
            old_mask_q  <= '0;
            out_vdata_q <= '0;
            out_vmask_q <= '0;
            out_idata_q <= '0;
            out_err_q   <= 1'b0;
        end else if (flush) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            out_vdata_q <= '0;
            out_vmask_q <= '0;
            out_idata_q <= '0;
            out_err_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        slide_up_q <= (bus.op == OP_SLIDEUP);
                        eidx_q     <= eidx_d;
                        cnt_q      <= cnt_d;
                        acc_data_q <= bus.src_data;
                        acc_mask_q <= bus.src_mask;
                        sel_q      <= '1;
                        old_data_q <= bus.old_data;
                        old_mask_q <= bus.old_mask;
                        if (cnt_d != '0) begin
                            state_q <= S_BUSY;
                        end else begin
                            state_q     <= S_DONE;
                            out_vdata_q <= imm_vdata_d;
                            out_vmask_q <= imm_vmask_d;
                            out_idata_q <= imm_idata_d;
                            out_err_q   <= !legal_d;
                        end
                    end
                end
                S_BUSY: begin
                    acc_data_q <= acc_data_d;
                    acc_mask_q <= acc_mask_d;
                    sel_q      <= sel_d;
                    cnt_q      <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_q     <= S_DONE;
                        out_vdata_q <= fin_data_d;
                        out_vmask_q <= fin_mask_d;
                        out_idata_q <= '0;
                        out_err_q   <= 1'b0;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        state_q     <= S_IDLE;
                        out_vdata_q <= '0;
                        out_vmask_q <= '0;
                        out_idata_q <= '0;
                        out_err_q   <= 1'b0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state_q == S_IDLE) && !flush;
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.out_vdata = out_vdata_q;
    assign bus.out_vmask = out_vmask_q;
    assign bus.out_idata = out_idata_q;
    assign bus.out_err   = out_err_q;
    assign dbg_state_o   = state_q;
endmodule

// File: tb/tb_riscv_v_permutation_unit.sv
// Bench for riscv_v_permutation_unit: element-level reference model,
// expected-result queue and a per-cycle compare process.
module tb_riscv_v_permutation_unit;
  localparam int DW = 128;
  localparam int IW = 32;
  localparam int NB = DW / 8;

  typedef struct {
    logic [DW-1:0] vdata;
    logic [NB-1:0] vmask;
    logic [IW-1:0] idata;
    logic          err;
    int            lat;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       flush = 1'b0;
  logic [1:0] dbg_state;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   accept_cyc = 0;
  bit   seen = 1'b0;
  exp_t exp_q[$];

  riscv_v_permutation_unit_if #(.DATA_WIDTH(DW), .INT_WIDTH(IW)) bus ();

  riscv_v_permutation_unit #(.DATA_WIDTH(DW), .INT_WIDTH(IW)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .flush(flush),
    .bus(bus),
    .dbg_state_o(dbg_state)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic logic [DW-1:0] rnd_vec();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Reference model: element-indexed rules, one bit/byte at a time
  function automatic exp_t model(input logic [1:0] op, input logic [4:0] osz,
                                 input logic [DW-1:0] src, input logic [NB-1:0] sm,
                                 input logic [DW-1:0] old, input logic [NB-1:0] om,
                                 input logic [IW-1:0] ks);
    exp_t   r;
    int     e, n, nb, i;
    longint k;
    r.vdata = '0;
    r.vmask = '0;
    r.idata = '0;
    r.err   = 1'b0;
    r.lat   = 1;
    if ($countones(osz) != 1) begin
      r.err = 1'b1;
      return r;
    end
    e = 8;
    for (int s = 0; s < 5; s++) if (osz[s]) e = 8 << s;
    n  = DW / e;
    nb = e / 8;
    k  = longint'(ks);
    case (op)
      2'd0: begin
        r.vdata = old;
        r.vmask = om;
        for (int b = 0; b < IW; b++) r.idata[b] = (b < e) ? src[b] : src[e-1];
      end
      2'd1: begin
        for (int b = 0; b < DW; b++) r.vdata[b] = (b < e) ? ((b < IW) ? ks[b] : ks[IW-1]) : old[b];
        for (int j = 0; j < NB; j++) r.vmask[j] = (j < nb) ? 1'b1 : om[j];
      end
      2'd2: begin
        for (int b = 0; b < DW; b++) begin
          i = b / e;
          r.vdata[b] = (i < k) ? old[b] : src[b - int'(k) * e];
        end
        for (int j = 0; j < NB; j++) begin
          i = j / nb;
          r.vmask[j] = (i < k) ? om[j] : sm[j - int'(k) * nb];
        end
      end
      default: begin
        for (int b = 0; b < DW; b++) begin
          i = b / e;
          r.vdata[b] = (longint'(i) + k < n) ? src[b + int'(k) * e] : 1'b0;
        end
        for (int j = 0; j < NB; j++) begin
          i = j / nb;
          r.vmask[j] = (longint'(i) + k < n) ? sm[j + int'(k) * nb] : 1'b0;
        end
      end
    endcase
    if (op[1]) r.lat = 1 + ((k < n) ? int'(k) : n);
    return r;
  endfunction

  // Scoreboard compare: every cycle a result is presented
  always @(negedge clk) begin
    if (rst_n && bus.out_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid actual=1 required=0");
      end else begin
        chk("vdata", bus.out_vdata, exp_q[0].vdata);
        chk("vmask", DW'(bus.out_vmask), DW'(exp_q[0].vmask));
        chk("idata", DW'(bus.out_idata), DW'(exp_q[0].idata));
        chk("err", DW'(bus.out_err), DW'(exp_q[0].err));
        chk("in_ready_while_valid", DW'(bus.in_ready), '0);
        if (!seen) begin
          seen = 1'b1;
          chk("latency", DW'(cyc - accept_cyc + 1), DW'(exp_q[0].lat));
        end
        if (bus.out_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic scramble();
    bus.op       = 2'($urandom_range(0, 3));
    bus.osize    = 5'($urandom);
    bus.src_data = rnd_vec();
    bus.old_data = rnd_vec();
    bus.src_mask = NB'($urandom);
    bus.old_mask = NB'($urandom);
    bus.int_src  = $urandom();
  endtask

  task automatic drive(input logic [1:0] op, input logic [4:0] osz,
                       input logic [DW-1:0] src, input logic [NB-1:0] sm,
                       input logic [DW-1:0] old, input logic [NB-1:0] om,
                       input logic [IW-1:0] ks);
    bus.op       = op;
    bus.osize    = osz;
    bus.src_data = src;
    bus.src_mask = sm;
    bus.old_data = old;
    bus.old_mask = om;
    bus.int_src  = ks;
    bus.in_valid = 1'b1;
  endtask

  task automatic wait_valid(output bit ok);
    int n = 0;
    while (!bus.out_valid && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    ok = bus.out_valid;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL valid_timeout actual=0 required=1");
      exp_q.delete();
    end
  endtask

  // One full transaction: issue, optional back-pressure, drain
  task automatic run_op(input logic [1:0] op, input logic [4:0] osz,
                        input logic [DW-1:0] src, input logic [NB-1:0] sm,
                        input logic [DW-1:0] old, input logic [NB-1:0] om,
                        input logic [IW-1:0] ks, input int hold);
    bit         ok;
    int         n;
    logic [1:0] st0;
    @(negedge clk);
    drive(op, osz, src, sm, old, om, ks);
    bus.out_ready = (hold == 0);
    #1;
    chk("in_ready_idle", DW'(bus.in_ready), DW'(1'b1));
    exp_q.push_back(model(op, osz, src, sm, old, om, ks));
    seen = 1'b0;
    @(posedge clk);
    #1;
    accept_cyc   = cyc;
    bus.in_valid = 1'b0;
    scramble();
    wait_valid(ok);
    if (ok) begin
      st0 = dbg_state;
      repeat (hold) begin
        @(posedge clk);
        #1;
      end
      if (hold > 0) chk("state_stable_hold", DW'(dbg_state), DW'(st0));
    end
    bus.out_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout actual=%0d required=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, DW'(bus.in_ready), DW'(1'b1));
    chk({tag, "_out_valid"}, DW'(bus.out_valid), '0);
    chk({tag, "_vdata"}, bus.out_vdata, '0);
    chk({tag, "_vmask"}, DW'(bus.out_vmask), '0);
    chk({tag, "_idata"}, DW'(bus.out_idata), '0);
    chk({tag, "_err"}, DW'(bus.out_err), '0);
  endtask

  initial begin
    exp_t          m;
    bit            ok;
    logic [DW-1:0] v_src, v_old, v_exp;
    logic [31:0]   wa, wb, wc, wd, ww, wx, wy, wz;
    logic [1:0]    r_op;
    logic [4:0]    r_osz;
    logic [IW-1:0] r_k;

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    scramble();

    // reset
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // hand-computed values pinning the model
    v_src = '0;
    v_src[7:0] = 8'hF0;
    m = model(2'd0, 5'b00001, v_src, '0, '0, '0, '0);
    chk("pin_v2i_b", DW'(m.idata), DW'(32'hFFFF_FFF0));
    v_src = rnd_vec();
    v_src[31:0] = 32'h1234_5678;
    m = model(2'd0, 5'b00100, v_src, '0, '0, '0, '0);
    chk("pin_v2i_d", DW'(m.idata), DW'(32'h1234_5678));
    m = model(2'd1, 5'b01000, rnd_vec(), '0, '1, 16'hFFFF, 32'h8000_0001);
    chk("pin_i2v_q", m.vdata, {64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_8000_0001});
    chk("pin_i2v_q_mask", DW'(m.vmask), DW'(16'hFFFF));
    wa = 32'hAAAA_0001; wb = 32'hBBBB_0002; wc = 32'hCCCC_0003; wd = 32'hDDDD_0004;
    ww = 32'h1111_000A; wx = 32'h2222_000B; wy = 32'h3333_000C; wz = 32'h4444_000D;
    m = model(2'd2, 5'b00100, {wd, wc, wb, wa}, 16'h1234, {wz, wy, wx, ww}, 16'hABCD, 32'd1);
    v_exp = {wc, wb, wa, ww};
    chk("pin_slideup", m.vdata, v_exp);
    chk("pin_slideup_mask", DW'(m.vmask), DW'(16'h234D));
    chk("pin_slideup_lat", DW'(m.lat), DW'(2));
    m = model(2'd3, 5'b00010, rnd_vec(), '1, rnd_vec(), '1, 32'd9);
    chk("pin_slidedown_data", m.vdata, '0);
    chk("pin_slidedown_mask", DW'(m.vmask), '0);
    chk("pin_slidedown_lat", DW'(m.lat), DW'(9));
    m = model(2'd1, 5'b00011, rnd_vec(), '1, rnd_vec(), '1, 32'd5);
    chk("pin_illegal_err", DW'(m.err), DW'(1'b1));
    chk("pin_illegal_data", m.vdata, '0);

    // directed transactions through the DUT
    v_src = rnd_vec();
    v_src[7:0] = 8'hF0;
    run_op(2'd0, 5'b00001, v_src, NB'($urandom), rnd_vec(), NB'($urandom), $urandom(), 0);
    run_op(2'd0, 5'b00100, rnd_vec(), NB'($urandom), rnd_vec(), NB'($urandom), $urandom(), 1);
    run_op(2'd1, 5'b01000, rnd_vec(), NB'($urandom), '1, 16'hFFFF, 32'h8000_0001, 0);
    run_op(2'd2, 5'b00100, {wd, wc, wb, wa}, 16'h1234, {wz, wy, wx, ww}, 16'hABCD, 32'd1, 0);
    run_op(2'd3, 5'b00010, rnd_vec(), '1, rnd_vec(), '1, 32'd9, 3);
    run_op(2'd2, 5'b10000, rnd_vec(), NB'($urandom), rnd_vec(), NB'($urandom), 32'd0, 0);
    run_op(2'd2, 5'b00001, rnd_vec(), NB'($urandom), rnd_vec(), NB'($urandom), 32'd16, 0);
    run_op(2'd1, 5'b00011, rnd_vec(), NB'($urandom), rnd_vec(), NB'($urandom), 32'd3, 0);
    run_op(2'd3, 5'b00001, rnd_vec(), NB'($urandom), rnd_vec(), NB'($urandom), 32'd3, 0);

    // flush while sliding; the killed op must never present a result
    @(negedge clk);
    drive(2'd2, 5'b00001, rnd_vec(), NB'($urandom), rnd_vec(), NB'($urandom), 32'd4);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    flush = 1'b1;
    bus.in_valid = 1'b1;
    #1;
    chk("in_ready_during_flush", DW'(bus.in_ready), '0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    chk("in_ready_after_flush", DW'(bus.in_ready), DW'(1'b1));
    chk("out_valid_after_flush", DW'(bus.out_valid), '0);
    repeat (8) begin
      @(posedge clk);
      #1;
    end

    // async reset while a result waits in DONE
    @(negedge clk);
    drive(2'd3, 5'b00100, rnd_vec(), NB'($urandom), rnd_vec(), NB'($urandom), 32'd2);
    bus.out_ready = 1'b0;
    exp_q.push_back(model(2'd3, 5'b00100, bus.src_data, bus.src_mask, bus.old_data, bus.old_mask, 32'd2));
    seen = 1'b0;
    @(posedge clk);
    #1;
    accept_cyc   = cyc;
    bus.in_valid = 1'b0;
    wait_valid(ok);
    @(negedge clk);
    #2;
    exp_q.delete();
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    run_op(2'd1, 5'b00001, rnd_vec(), NB'($urandom), rnd_vec(), NB'($urandom), $urandom(), 0);

    // randomized traffic
    for (int t = 0; t < 150; t++) begin
      r_op = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) r_osz = 5'($urandom);
      else                           r_osz = 5'd1 << $urandom_range(0, 4);
      if ($urandom_range(0, 7) == 0) r_k = $urandom();
      else                           r_k = IW'($urandom_range(0, 18));
      run_op(r_op, r_osz, rnd_vec(), NB'($urandom), rnd_vec(), NB'($urandom), r_k,
             int'($urandom_range(0, 2)));
    end

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
